// File: rtl/lighthouse_pulse_decoder.sv
// lighthouse_pulse_decoder
//
// Measures light pulses on the TS4231 envelope line while the sensor is in
// WATCH state. Each pulse is classified as a sweep, a Lighthouse v1 sync
// (code 0..7) or an error. Sweeps are timed against the last non-skip sync
// (the "anchor") to produce the raw value used for angle computation.
//
// Ports:
//   clk              clock
//   rst              synchronous, active-high reset
//   enable           high while upstream reports WATCH state
//   envelope         asynchronous envelope input, high = light
//   sweep_valid      one-cycle strobe for an accepted sweep
//   sweep_duration   cycles from anchor sync rise to sweep pulse centre
//   sweep_axis       axis bit of the anchor sync
//   sweep_lighthouse pair index of the anchor sync
//   sync_valid       one-cycle strobe per decoded sync
//   sync_code        {skip, data, axis}
//   sync_lighthouse  0 = first sync of a pair, 1 = later sync
//   pulse_error      one-cycle strobe for an unclassifiable pulse
module lighthouse_pulse_decoder #(
    parameter int CLK_SPEED       = 50_000_000,
    parameter int TIME_W          = 20,
    parameter int SWEEP_MAX_NS    = 40000,
    parameter int PAIR_WINDOW_NS  = 600000,
    parameter int SWEEP_WINDOW_NS = 8333333,
    parameter int SYNC_BASE_NS    = 57292,
    parameter int SYNC_STEP_NS    = 10417
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              envelope,
    output logic              sweep_valid,
    output logic [TIME_W-1:0] sweep_duration,
    output logic              sweep_axis,
    output logic              sweep_lighthouse,
    output logic              sync_valid,
    output logic [2:0]        sync_code,
    output logic              sync_lighthouse,
    output logic              pulse_error
);

    localparam logic [63:0] NS_PER_S  = 64'd1_000_000_000;
    localparam logic [63:0] SWEEP_MAX = (64'(CLK_SPEED) * 64'(SWEEP_MAX_NS)) / NS_PER_S;
    localparam logic [63:0] PAIR_WIN  = (64'(CLK_SPEED) * 64'(PAIR_WINDOW_NS)) / NS_PER_S;
    localparam logic [63:0] SWEEP_WIN = (64'(CLK_SPEED) * 64'(SWEEP_WINDOW_NS)) / NS_PER_S;
    localparam logic [TIME_W-1:0] TIME_MAX  = {TIME_W{1'b1}};
    localparam logic [15:0]       WIDTH_MAX = 16'hFFFF;

    typedef enum logic [2:0] {IDLE, ARM, WAIT_RISE, MEASURE, CLASSIFY} state_t;
    state_t state_reg, state_next;

    logic env_meta_reg, env_s_reg, env_d_reg;
    logic rise, fall;

    logic [15:0]       width_reg;
    logic [TIME_W-1:0] pulse_age_reg;    // cycles since the current pulse rose
    logic [TIME_W-1:0] gap_reg;          // cycles since the last committed sync rise
    logic [TIME_W-1:0] gap_at_rise_reg;
    logic              gap_valid_reg;
    logic [TIME_W-1:0] age_reg;          // anchor age
    logic [TIME_W-1:0] age_at_rise_reg;
    logic              anchor_valid_reg, anchor_axis_reg, anchor_lh_reg;

    logic [8:0]        at_or_above;
    logic              is_sweep, is_sync, sync_lh;
    logic [2:0]        code;
    logic [TIME_W-1:0] pulse_age_inc, dur_sat;
    logic [TIME_W:0]   dur_sum;

    assign rise = env_s_reg & ~env_d_reg;
    assign fall = ~env_s_reg & env_d_reg;

    // One comparator per sync threshold T_k.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_thr
            localparam logic [63:0] THR =
                (64'(CLK_SPEED) * (64'(SYNC_BASE_NS) + 64'(gi) * 64'(SYNC_STEP_NS))) / NS_PER_S;
            assign at_or_above[gi] = (64'(width_reg) >= THR);
        end
    endgenerate

    always_comb begin
        is_sweep = (64'(width_reg) <= SWEEP_MAX);
        is_sync  = at_or_above[0] & ~at_or_above[8];
        code     = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (at_or_above[k]) code = 3'(k);
        end
        sync_lh       = gap_valid_reg && (64'(gap_at_rise_reg) < PAIR_WIN);
        pulse_age_inc = (pulse_age_reg == TIME_MAX) ? pulse_age_reg : pulse_age_reg + 1'b1;
        dur_sum       = {1'b0, age_at_rise_reg} + (TIME_W+1)'(width_reg >> 1);
        dur_sat       = dur_sum[TIME_W] ? TIME_MAX : dur_sum[TIME_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:      state_next = ARM;
                ARM:       if (!env_s_reg) state_next = WAIT_RISE;
                WAIT_RISE: if (rise) state_next = MEASURE;
                MEASURE:   if (fall) state_next = CLASSIFY;
                CLASSIFY:  state_next = WAIT_RISE;
                default:   state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchronizer resets to "light present" so a pulse already high
            // when reset releases is never mistaken for a fresh rise.
            env_meta_reg     <= 1'b1;
            env_s_reg        <= 1'b1;
            env_d_reg        <= 1'b1;
            width_reg        <= '0;
            pulse_age_reg    <= '0;
            gap_reg          <= '0;
            gap_at_rise_reg  <= '0;
            gap_valid_reg    <= 1'b0;
            age_reg          <= '0;
            age_at_rise_reg  <= '0;
            anchor_valid_reg <= 1'b0;
            anchor_axis_reg  <= 1'b0;
            anchor_lh_reg    <= 1'b0;
            sweep_valid      <= 1'b0;
            sweep_duration   <= '0;
            sweep_axis       <= 1'b0;
            sweep_lighthouse <= 1'b0;
            sync_valid       <= 1'b0;
            sync_code        <= 3'd0;
            sync_lighthouse  <= 1'b0;
            pulse_error      <= 1'b0;
        end else begin
            env_meta_reg  <= envelope;
            env_s_reg     <= env_meta_reg;
            env_d_reg     <= env_s_reg;
            sweep_valid   <= 1'b0;
            sync_valid    <= 1'b0;
            pulse_error   <= 1'b0;
            gap_reg       <= (gap_reg == TIME_MAX) ? gap_reg : gap_reg + 1'b1;
            pulse_age_reg <= pulse_age_inc;

            if (anchor_valid_reg) begin
                if (age_reg != TIME_MAX) age_reg <= age_reg + 1'b1;
                if (64'(age_reg) + 64'd1 >= SWEEP_WIN) anchor_valid_reg <= 1'b0;
            end

            if (!enable) begin
                width_reg        <= '0;
                gap_valid_reg    <= 1'b0;
                anchor_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    WAIT_RISE: begin
                        if (rise) begin
                            // Rise timing is latched for every pulse; it is
                            // only used once the pulse classifies.
                            width_reg       <= 16'd1;
                            pulse_age_reg   <= TIME_W'(1);
                            gap_at_rise_reg <= gap_reg;
                            age_at_rise_reg <= age_reg;
                        end
                    end
                    MEASURE: begin
                        if (env_s_reg && width_reg != WIDTH_MAX) width_reg <= width_reg + 16'd1;
                    end
                    CLASSIFY: begin
                        width_reg <= '0;
                        if (is_sweep) begin
                            if (anchor_valid_reg) begin
                                sweep_valid      <= 1'b1;
                                sweep_duration   <= dur_sat;
                                sweep_axis       <= anchor_axis_reg;
                                sweep_lighthouse <= anchor_lh_reg;
                                anchor_valid_reg <= 1'b0;
                            end
                        end else if (is_sync) begin
                            sync_valid      <= 1'b1;
                            sync_code       <= code;
                            sync_lighthouse <= sync_lh;
                            // Back-date the gap counter to this sync's rise.
                            gap_reg         <= pulse_age_inc;
                            gap_valid_reg   <= 1'b1;
                            if (!code[2]) begin
                                anchor_valid_reg <= (64'(pulse_age_inc) < SWEEP_WIN);
                                age_reg          <= pulse_age_inc;
                                anchor_axis_reg  <= code[0];
                                anchor_lh_reg    <= sync_lh;
                            end
                        end else begin
                            pulse_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lighthouse_pulse_decoder.sv
// Self-checking bench for lighthouse_pulse_decoder, run at CLK_SPEED = 1.25 MHz
// so all windows are 40x shorter: T_k = 71,84,97,110,123,136,149,162,175,
// SWEEP_MAX = 50, PAIR_WIN = 750, SWEEP_WIN = 10416.
module tb_lighthouse_pulse_decoder;

    localparam longint CLK = 1_250_000;

    logic        clk, rst, enable, envelope;
    logic        sweep_valid, sweep_axis, sweep_lighthouse;
    logic [19:0] sweep_duration;
    logic        sync_valid, sync_lighthouse, pulse_error;
    logic [2:0]  sync_code;

    lighthouse_pulse_decoder #(.CLK_SPEED(1_250_000)) dut (
        .clk(clk), .rst(rst), .enable(enable), .envelope(envelope),
        .sweep_valid(sweep_valid), .sweep_duration(sweep_duration),
        .sweep_axis(sweep_axis), .sweep_lighthouse(sweep_lighthouse),
        .sync_valid(sync_valid), .sync_code(sync_code),
        .sync_lighthouse(sync_lighthouse), .pulse_error(pulse_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;
    int strobe_seen = 0;
    bit armed = 0;

    typedef struct {
        longint due;
        bit     is_sync, is_sweep, is_err;
        logic [2:0] code;
        bit     lh;
        longint dur;
        bit     axis;
    } exp_t;
    exp_t q[$];

    // Reference model state, expressed in pulse rise times and widths.
    longint thr[9];
    longint smax, pwin, swin;
    bit     anc_v, anc_axis, anc_lh, last_v;
    longint anc_r, last_r;

    task automatic model_pulse(input longint r, input longint w);
        exp_t e;
        int   k;
        bit   lh;
        e = '{due: r + w + 4, is_sync: 0, is_sweep: 0, is_err: 0,
              code: 3'd0, lh: 0, dur: 0, axis: 0};
        if (w <= smax) begin
            if (anc_v && (r + w + 1 - anc_r) < swin) begin
                e.is_sweep = 1;
                e.dur  = (r - anc_r) + w / 2;
                if (e.dur > 1048575) e.dur = 1048575;
                e.axis = anc_axis;
                e.lh   = anc_lh;
            end
            anc_v = 0;
        end else if (w >= thr[0] && w < thr[8]) begin
            k = 0;
            for (int j = 1; j < 8; j++) if (w >= thr[j]) k = j;
            lh = last_v && ((r - last_r) < pwin);
            last_v = 1;
            last_r = r;
            e.is_sync = 1;
            e.code = 3'(k);
            e.lh = lh;
            if (k < 4) begin
                anc_v = 1; anc_r = r; anc_axis = e.code[0]; anc_lh = lh;
            end
        end else begin
            e.is_err = 1;
        end
        if (e.is_sync || e.is_sweep || e.is_err) q.push_back(e);
    endtask

    task automatic model_disable();
        anc_v = 0;
        last_v = 0;
    endtask

    // Per-cycle compare against the model's expected strobes and held values.
    logic [2:0]  h_code = 0;
    logic        h_slh = 0, h_ax = 0, h_wlh = 0;
    logic [19:0] h_dur = 0;
    always @(negedge clk) begin
        bit es, ew, ee;
        exp_t ev;
        es = 0; ew = 0; ee = 0;
        if (armed) begin
            if (rst) begin
                q.delete();
                h_code = 0; h_slh = 0; h_ax = 0; h_wlh = 0; h_dur = 0;
            end else if (q.size() > 0 && q[0].due == cyc) begin
                ev = q.pop_front();
                es = ev.is_sync; ew = ev.is_sweep; ee = ev.is_err;
                if (es) begin h_code = ev.code; h_slh = ev.lh; end
                if (ew) begin h_dur = 20'(ev.dur); h_ax = ev.axis; h_wlh = ev.lh; end
            end
            if (sync_valid || sweep_valid || pulse_error) begin
                strobe_seen++;
                $display("cyc %0d: sync=%0b code=%0d lh=%0b | sweep=%0b dur=%0d axis=%0b lh=%0b | err=%0b",
                         cyc, sync_valid, sync_code, sync_lighthouse, sweep_valid,
                         sweep_duration, sweep_axis, sweep_lighthouse, pulse_error);
            end
            checks++;
            if ({sync_valid, sweep_valid, pulse_error} !== {es, ew, ee} ||
                sync_code !== h_code || sync_lighthouse !== h_slh ||
                sweep_duration !== h_dur || sweep_axis !== h_ax || sweep_lighthouse !== h_wlh)
                $display("FAIL cycle %0d outputs: got sv=%b code=%0d slh=%b wv=%b dur=%0d ax=%b wlh=%b err=%b, required sv=%b code=%0d slh=%b wv=%b dur=%0d ax=%b wlh=%b err=%b",
                         cyc, sync_valid, sync_code, sync_lighthouse, sweep_valid, sweep_duration,
                         sweep_axis, sweep_lighthouse, pulse_error,
                         es, h_code, h_slh, ew, h_dur, h_ax, h_wlh, ee);
            else
                passed++;
        end
    end

    task automatic lit(input string name, input longint got, input longint req);
        checks++;
        if (got == req) passed++;
        else $display("FAIL %s: got %0d required %0d", name, got, req);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    longint last_rise;

    task automatic pulse_at(input longint rise, input int w, input bit to_model);
        while (cyc < rise) tick(1);
        envelope = 1'b1;
        last_rise = cyc;
        tick(w);
        envelope = 1'b0;
        if (to_model) model_pulse(last_rise, w);
        $display("pulse rise=%0d width=%0d", last_rise, w);
    endtask

    task automatic at_due(input int w);
        while (cyc < last_rise + w + 4) tick(1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        longint s1, x, a, b, c, d, e, nr;
        int w, sel;

        for (int k = 0; k < 9; k++) thr[k] = (CLK * (57292 + k * 10417)) / 1000000000;
        smax = (CLK * 40000) / 1000000000;
        pwin = (CLK * 600000) / 1000000000;
        swin = (CLK * 8333333) / 1000000000;
        anc_v = 0; last_v = 0; anc_r = 0; last_r = 0; anc_axis = 0; anc_lh = 0;

        // Reset with the envelope high.
        rst = 1'b1; enable = 1'b1; envelope = 1'b1;
        tick(5);
        armed = 1;
        lit("reset outputs", longint'({sweep_valid, sweep_duration, sweep_axis, sweep_lighthouse,
                                        sync_valid, sync_code, sync_lighthouse, pulse_error}), 0);
        rst = 1'b0;
        tick(300);
        lit("no strobe while held high", strobe_seen, 0);
        envelope = 1'b0;

        // Sync pair then sweep.
        s1 = cyc + 1000;
        pulse_at(s1, 125, 1); at_due(125);
        lit("sync1 valid", sync_valid, 1); lit("sync1 code", sync_code, 4); lit("sync1 lh", sync_lighthouse, 0);
        pulse_at(s1 + 500, 87, 1); at_due(87);
        lit("sync2 valid", sync_valid, 1); lit("sync2 code", sync_code, 1); lit("sync2 lh", sync_lighthouse, 1);
        pulse_at(s1 + 5500, 10, 1); at_due(10);
        lit("sweep valid", sweep_valid, 1); lit("sweep dur", sweep_duration, 5005);
        lit("sweep axis", sweep_axis, 1); lit("sweep lh", sweep_lighthouse, 1);

        // Width boundaries.
        x = cyc + 500;
        pulse_at(x, 50, 1); at_due(50);
        lit("w50 strobes", {sync_valid, sweep_valid, pulse_error}, 0);
        pulse_at(x + 500, 51, 1); at_due(51);   lit("w51 error", pulse_error, 1);
        pulse_at(x + 1000, 70, 1); at_due(70);  lit("w70 error", pulse_error, 1);
        pulse_at(x + 1500, 71, 1); at_due(71);
        lit("w71 sync", sync_valid, 1); lit("w71 code", sync_code, 0);
        pulse_at(x + 2000, 174, 1); at_due(174);
        lit("w174 sync", sync_valid, 1); lit("w174 code", sync_code, 7);
        pulse_at(x + 2500, 175, 1); at_due(175);
        lit("w175 error", pulse_error, 1); lit("w175 no sync", sync_valid, 0);

        // Anchor lifetime.
        a = cyc + 1000;
        pulse_at(a, 75, 1);
        pulse_at(a + 10450, 20, 1); at_due(20);
        lit("expired anchor sweep", sweep_valid, 0);
        b = cyc + 1000;
        pulse_at(b, 75, 1);
        pulse_at(b + 1000, 20, 1); at_due(20);
        lit("first sweep valid", sweep_valid, 1); lit("first sweep dur", sweep_duration, 1010);
        pulse_at(b + 5000, 20, 1); at_due(20);
        lit("second sweep", sweep_valid, 0);

        // Sync pair gap boundary.
        c = cyc + 1000;
        pulse_at(c, 125, 1);
        pulse_at(c + 749, 125, 1); at_due(125);   lit("gap 749 lh", sync_lighthouse, 1);
        d = c + 749 + 2000;
        pulse_at(d, 125, 1); at_due(125);         lit("gap 2000 lh", sync_lighthouse, 0);
        pulse_at(d + 750, 125, 1); at_due(125);   lit("gap 750 lh", sync_lighthouse, 0);

        // Disable mid-sweep, re-enable with the envelope still high.
        e = d + 750 + 2000;
        pulse_at(e, 75, 1);
        while (cyc < e + 500) tick(1);
        envelope = 1'b1;
        tick(20); enable = 1'b0; model_disable();
        tick(10); enable = 1'b1;
        tick(30); envelope = 1'b0;
        tick(4);
        lit("aborted sweep strobes", {sync_valid, sweep_valid, pulse_error}, 0);
        pulse_at(e + 1000, 20, 1); at_due(20);
        lit("sweep after disable", sweep_valid, 0);
        pulse_at(e + 1300, 75, 1); at_due(75);
        lit("sync after enable lh", sync_lighthouse, 0);

        // Randomized pulse train.
        nr = cyc + 100;
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) w = $urandom_range(71, 174);
            else if (sel == 4) w = ($urandom_range(0, 1) == 1) ? $urandom_range(51, 70) : $urandom_range(175, 200);
            else w = $urandom_range(1, 50);
            pulse_at(nr, w, 1);
            if ($urandom_range(0, 3) == 0) nr = last_rise + $urandom_range(745, 755);
            else nr = last_rise + w + 5 + $urandom_range(0, 500);
        end

        tick(300);
        lit("expected events drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lighthouse_pulse_decoder.md
Name: lighthouse_pulse_decoder

Overview:
Sits directly downstream of the TS4231 configuration/state-control block. Once the sensor is in WATCH state, this block consumes the sensor's envelope output (E line, light present = high). It measures every light pulse, classifies it as a Lighthouse v1 sync pulse or a sweep pulse, and decodes the sync code. For each accepted sweep it emits the sweep timing relative to the last non-skip sync, which is the raw input to angle computation.

Parameters:
CLK_SPEED, 50_000_000, clk frequency in Hz
TIME_W, 20, width of sweep_duration and the anchor age counter
SWEEP_MAX_NS, 40000, longest pulse classified as a sweep
PAIR_WINDOW_NS, 600000, max gap between sync rises for them to count as the same sync pair
SWEEP_WINDOW_NS, 8333333, anchor lifetime after a non-skip sync
SYNC_BASE_NS, 57292, lower bound of sync code 0
SYNC_STEP_NS, 10417, width step per sync code

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
enable  in  1  high while the upstream block reports the sensor in WATCH state
envelope  in  1  asynchronous sensor envelope, high = light
sweep_valid  out  1  one-cycle strobe
sweep_duration  out  TIME_W  cycles from anchor sync rise to sweep pulse centre
sweep_axis  out  1  axis bit of the anchor sync
sweep_lighthouse  out  1  pair index of the anchor sync
sync_valid  out  1  one-cycle strobe per decoded sync
sync_code  out  3  {skip, data, axis}
sync_lighthouse  out  1  0 = first sync of a pair, 1 = later
pulse_error  out  1  one-cycle strobe for an unclassifiable pulse

Behaviour:
- Reset: clk is the clock; rst is a synchronous, active-high reset. All outputs are 0. The anchor is invalid, counters are cleared, and the FSM is in IDLE.
- Input conditioning:
  - envelope passes through a 2-flop synchronizer to give env_s; env_s is delayed one more flop to detect edges.
  - All timing is measured on env_s.
- Sync width thresholds:
  - T_k = floor(CLK_SPEED*(SYNC_BASE_NS+k*SYNC_STEP_NS)/1e9), k = 0..8, evaluated in 64-bit localparams.
  - At 50 MHz: 2864, 3385, 3906, 4427, 4948, 5468, 5989, 6510, 7031.
  - SWEEP_MAX = floor(CLK_SPEED*SWEEP_MAX_NS/1e9) = 2000.
  - PAIR_WIN = 30000 and SWEEP_WIN = 416666 cycles, derived the same way.
- FSM states:
  - IDLE: waits for enable.
  - ARM: waits for env_s low.
  - WAIT_RISE.
  - MEASURE: a 16-bit saturating width counter increments every cycle env_s is high; width = number of high cycles.
  - CLASSIFY: one cycle, entered on the falling edge.
  - Transitions: ARM to WAIT_RISE when env_s is low. WAIT_RISE to MEASURE on a rising edge. MEASURE to CLASSIFY on a falling edge. CLASSIFY to WAIT_RISE.
- Output timing: strobes assert in the CLASSIFY cycle and are registered. Latency is 1 cycle after the falling edge of env_s, 4 clk after the raw fall.
- Classification:
  - width <= SWEEP_MAX: sweep.
  - T_k <= width < T_{k+1}: sync, code k.
  - Otherwise (SWEEP_MAX < width < T_0, or width >= T_8): pulse_error, with no other effect.
- Sync handling:
  - A free sync-gap counter (saturating) is reset at each sync rise.
  - sync_lighthouse = 1 if the gap to the previous sync rise is < PAIR_WIN, else 0.
  - The first sync after reset or enable gets 0.
  - The sync rise time is captured at the rising edge. The class is only known at the fall, so the rise time is latched on every rise and committed only when the pulse classifies as sync.
  - A non-skip sync (code[2]=0) loads the anchor: age = cycles since its rise, axis and lighthouse latched, anchor valid.
  - A skip sync leaves the anchor untouched.
- Anchor age:
  - Age increments every cycle while the anchor is valid.
  - The anchor is invalidated when age reaches SWEEP_WIN.
- Sweep handling:
  - If the anchor is valid at the sweep's CLASSIFY cycle: sweep_valid is asserted with sweep_duration = age_at_sweep_rise + (width>>1), and the anchor is invalidated (one sweep per sync).
  - The result saturates at 2^TIME_W-1.
  - If the anchor is invalid: no output.
- Disable: enable low in any state forces IDLE within 1 cycle, clears the anchor, the gap-valid flag and the width counter, and aborts any pulse in progress with no strobe. Re-enable goes through ARM, so a pulse already high is never measured.
- Reset mid-pulse: identical to disable, and all outputs return to 0.
- Data outputs: sweep_duration, sweep_axis, sweep_lighthouse, sync_code and sync_lighthouse hold their last values between strobes.

Test Plan:
1. Reset with envelope high -> all outputs 0; no strobes until envelope falls then rises.
2. Full sync pair sequence:
   - Quiet 40000 cycles, then sync width 5000 -> sync_valid, code=4, lighthouse=0.
   - Sync width 3500 rising 20000 cycles after the first -> sync_valid, code=1, lighthouse=1.
   - Sweep width 100 rising 200000 cycles after the second sync rise -> sweep_valid, duration=200050, axis=1, lighthouse=1.
3. Width boundaries -> 2000 no output (no anchor); 2001 and 2863 give pulse_error; 2864 code 0; 7030 code 7; 7031 pulse_error.
4. Anchor lifetime:
   - Sync code 0, sweep rising 416700 cycles later -> no sweep_valid.
   - Sync code 0, sweep at 1000, second sweep at 5000 -> only the first is reported (duration 1000 + width/2).
5. Sync-pair gap -> syncs 29999 cycles apart give sync_lighthouse 0 then 1; 30000 apart give 0 then 0.
6. Disable and re-enable:
   - enable drops mid-sweep after a valid sync -> no strobe, anchor cleared.
   - enable reasserted with envelope high -> no measurement until the next rise; a subsequent sweep gives no sweep_valid.
